// File: rtl/add_arbiter.sv
// add_arbiter: round-robin front end that time-shares one adder among NREQ
// requesters. Grant, operand capture, registered sum, then hold the result
// on a valid/ready port until the consumer takes it.

// Plain combinational adder; wraps modulo 2^DATAWIDTH.
module add_unit #(
    parameter int DATAWIDTH = 64
) (
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic [DATAWIDTH-1:0] sum
);
    assign sum = a + b;
endmodule

module add_arbiter #(
    parameter int DATAWIDTH = 64,
    parameter int NREQ      = 4,
    parameter int IDW       = 2
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [NREQ-1:0]           REQ,
    input  logic [NREQ*DATAWIDTH-1:0] A_IN,
    input  logic [NREQ*DATAWIDTH-1:0] B_IN,
    output logic [NREQ-1:0]           GNT,
    output logic [DATAWIDTH-1:0]      SUM_OUT,
    output logic [IDW-1:0]            SUM_ID,
    output logic                      SUM_VALID,
    input  logic                      OUT_READY
);

    typedef enum logic [1:0] {IDLE, COMPUTE, HOLD} state_t;

    state_t               state, state_nxt;
    logic [IDW-1:0]       ptr;
    logic [IDW-1:0]       sel;
    logic [IDW-1:0]       sel_inc;
    logic                 found;
    logic [IDW:0]         idx;
    logic [DATAWIDTH-1:0] opa, opb, add_sum;
    logic [IDW-1:0]       id;

    add_unit #(.DATAWIDTH(DATAWIDTH)) u_add (
        .a   (opa),
        .b   (opb),
        .sum (add_sum)
    );

    // Round-robin search: first set REQ bit at or above ptr, wrapping at NREQ.
    // idx carries one extra bit so ptr+k never overflows before the wrap.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NREQ))
                idx = idx - (IDW+1)'(NREQ);
            if (!found && REQ[idx[IDW-1:0]]) begin
                found = 1'b1;
                sel   = idx[IDW-1:0];
            end
        end
        sel_inc = (sel == IDW'(NREQ-1)) ? '0 : sel + 1'b1;
    end

    // State register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; REQ only matters in IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (found) state_nxt = COMPUTE;
            COMPUTE: state_nxt = HOLD;
            HOLD:    if (OUT_READY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant/capture in IDLE, publish sum in COMPUTE, drop valid on transfer.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ptr       <= '0;
            opa       <= '0;
            opb       <= '0;
            id        <= '0;
            GNT       <= '0;
            SUM_OUT   <= '0;
            SUM_ID    <= '0;
            SUM_VALID <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        opa <= A_IN[sel*DATAWIDTH +: DATAWIDTH];
                        opb <= B_IN[sel*DATAWIDTH +: DATAWIDTH];
                        id  <= sel;
                        GNT <= NREQ'(1) << sel;
                        ptr <= sel_inc;
                    end
                end
                COMPUTE: begin
                    SUM_OUT   <= add_sum;
                    SUM_ID    <= id;
                    SUM_VALID <= 1'b1;
                    GNT       <= '0;
                end
                HOLD: begin
                    if (OUT_READY)
                        SUM_VALID <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_add_arbiter.sv
// Randomized bench for add_arbiter with a transaction-level reference model:
// expected grantee from a modular round-robin search, expected sum from
// plain 64-bit addition of the operands presented at the grant edge.
module tb_add_arbiter;
    localparam int DW   = 64;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 Clk, Rst, OUT_READY, SUM_VALID;
    logic [NREQ-1:0]      REQ, GNT;
    logic [NREQ*DW-1:0]   A_IN, B_IN;
    logic [DW-1:0]        SUM_OUT;
    logic [IDW-1:0]       SUM_ID;

    logic [DW-1:0] a_v [NREQ];
    logic [DW-1:0] b_v [NREQ];
    int n_chk  = 0;
    int n_pass = 0;
    int m_ptr  = 0;

    add_arbiter #(.DATAWIDTH(DW), .NREQ(NREQ), .IDW(IDW)) dut (
        .Clk(Clk), .Rst(Rst), .REQ(REQ), .A_IN(A_IN), .B_IN(B_IN),
        .GNT(GNT), .SUM_OUT(SUM_OUT), .SUM_ID(SUM_ID),
        .SUM_VALID(SUM_VALID), .OUT_READY(OUT_READY)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            A_IN[i*DW +: DW] = a_v[i];
            B_IN[i*DW +: DW] = b_v[i];
        end
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        a_v[i] = a;
        b_v[i] = b;
        REQ[i] = 1'b1;
        drive();
    endtask

    // First requesting index at or after p, modulo NREQ; -1 if none.
    function automatic int pick(input int p, input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    // One full transaction: grant, result, optional stall, transfer.
    // Called at a negedge with REQ already nonzero and the DUT in IDLE.
    task automatic do_op(input int stall, input bit rereq);
        int g;
        logic [DW-1:0] e;
        g = pick(m_ptr, REQ);
        chk("req_pending", 64'(g >= 0), 64'd1);
        if (g < 0) return;
        e = a_v[g] + b_v[g];
        @(negedge Clk);
        chk("gnt", 64'(GNT), 64'(1 << g));
        chk("vld_at_gnt", 64'(SUM_VALID), 64'd0);
        m_ptr = (g + 1) % NREQ;
        // Requester drops REQ and scribbles its operand after the grant.
        REQ[g] = 1'b0;
        a_v[g] = rnd64();
        drive();
        @(negedge Clk);
        chk("vld", 64'(SUM_VALID), 64'd1);
        chk("sum", SUM_OUT, e);
        chk("id", 64'(SUM_ID), 64'(g));
        chk("gnt_clr", 64'(GNT), 64'd0);
        OUT_READY = (stall == 0);
        for (int s = 0; s < stall; s++) begin
            @(negedge Clk);
            chk("hold_vld", 64'(SUM_VALID), 64'd1);
            chk("hold_sum", SUM_OUT, e);
            chk("hold_id", 64'(SUM_ID), 64'(g));
            chk("hold_gnt", 64'(GNT), 64'd0);
        end
        OUT_READY = 1'b1;
        @(negedge Clk);
        chk("vld_drop", 64'(SUM_VALID), 64'd0);
        chk("gnt_idle", 64'(GNT), 64'd0);
        if (rereq) set_req(g, rnd64(), rnd64());
    endtask

    initial begin
        Rst = 1'b0;
        REQ = '0;
        OUT_READY = 1'b1;
        for (int i = 0; i < NREQ; i++) begin a_v[i] = '0; b_v[i] = '0; end
        drive();
        repeat (3) @(negedge Clk);
        chk("rst_gnt", 64'(GNT), 64'd0);
        chk("rst_vld", 64'(SUM_VALID), 64'd0);
        chk("rst_sum", SUM_OUT, 64'd0);
        chk("rst_id", 64'(SUM_ID), 64'd0);
        Rst = 1'b1;

        // Round-robin with every requester re-requesting: order 0,1,2,3,0.
        for (int i = 0; i < NREQ; i++) set_req(i, rnd64(), rnd64());
        for (int n = 0; n < 5; n++) do_op(0, 1'b1);
        REQ = '0;

        // Single request, 5 + 7.
        set_req(0, 64'd5, 64'd7);
        do_op(0, 1'b0);

        // Back-pressure with requester 2 waiting behind requester 1.
        set_req(1, rnd64(), rnd64());
        set_req(2, rnd64(), rnd64());
        do_op(10, 1'b0);
        do_op(0, 1'b0);

        // Wrap-around sums.
        set_req(0, {DW{1'b1}}, 64'd1);
        do_op(0, 1'b0);
        set_req(0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        do_op(1, 1'b0);

        // Random mix of request patterns, operands and stalls.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NREQ; i++)
                if (!REQ[i] && $urandom_range(0, 1) == 1)
                    set_req(i, ($urandom_range(0, 7) == 0) ? {DW{1'b1}} : rnd64(), rnd64());
            if (REQ == '0) set_req($urandom_range(0, NREQ-1), rnd64(), rnd64());
            do_op($urandom_range(0, 3), 1'b0);
        end
        REQ = '0;

        // Reset while holding a result.
        set_req(3, 64'd10, 64'd20);
        @(negedge Clk);
        chk("mid_gnt", 64'(GNT), 64'(1 << pick(m_ptr, 4'b1000)));
        REQ[3] = 1'b0;
        @(negedge Clk);
        chk("mid_vld", 64'(SUM_VALID), 64'd1);
        OUT_READY = 1'b0;
        repeat (2) @(negedge Clk);
        #2 Rst = 1'b0;
        #1;
        chk("arst_gnt", 64'(GNT), 64'd0);
        chk("arst_vld", 64'(SUM_VALID), 64'd0);
        chk("arst_sum", SUM_OUT, 64'd0);
        chk("arst_id", 64'(SUM_ID), 64'd0);
        m_ptr = 0;
        set_req(1, rnd64(), rnd64());
        set_req(3, rnd64(), rnd64());
        @(negedge Clk);
        Rst = 1'b1;
        OUT_READY = 1'b1;
        do_op(0, 1'b0);
        do_op(0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/add_arbiter.md
# add_arbiter

Shares a single ADD datapath instance among NREQ independent requesters. Each requester raises a request with its operand pair. A round-robin scheduler grants one requester at a time, latches its operands, computes the registered sum, and presents it with the requester's ID on a valid/ready output port. The block sits between the operand producers and the lone adder.

## Interface
- DATAWIDTH, 64, operand and sum width; passed to the internal ADD instance.
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, 2, ID width; must equal ceil(log2(NREQ)).
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst  input  1  asynchronous, active-low reset.
- REQ  input  NREQ  per-requester request; bit i held high with operands stable until GNT[i] is sampled.
- A_IN  input  NREQ*DATAWIDTH  packed A operands; requester i owns bits [i*DATAWIDTH +: DATAWIDTH].
- B_IN  input  NREQ*DATAWIDTH  packed B operands; same packing as A_IN.
- GNT  output  NREQ  registered one-hot grant; high for exactly one cycle per accepted request.
- SUM_OUT  output  DATAWIDTH  registered result.
- SUM_ID  output  IDW  index of the requester that owns SUM_OUT.
- SUM_VALID  output  1  SUM_OUT and SUM_ID are valid.
- OUT_READY  input  1  consumer accepts the result; a transfer occurs on the edge where SUM_VALID and OUT_READY are both 1.

## Operation
- The FSM has three states: IDLE, COMPUTE, HOLD.
- **IDLE**
  - If any REQ bit is set at an edge, select the first set bit, searching upward from PTR with wrap at NREQ.
  - Latch that requester's A and B slices into the operand registers and latch its index into the ID register.
  - Set GNT[i] = 1 and PTR = (i+1) mod NREQ, then go to COMPUTE.
  - If no REQ bit is set, stay in IDLE.
- **COMPUTE**
  - The internal ADD sees the latched operands.
  - On the next edge: SUM_OUT = (A + B) mod 2^DATAWIDTH, SUM_ID = latched index, SUM_VALID = 1, GNT = 0, go to HOLD.
- **HOLD**
  - SUM_OUT, SUM_ID and SUM_VALID stay constant while OUT_READY = 0, with no timeout.
  - On the transfer edge: SUM_VALID = 0, go to IDLE.
- REQ is ignored in COMPUTE and HOLD.
- Requesters must deassert REQ on the edge where they sample GNT = 1. Otherwise the request is treated as a new request at the next IDLE.
- Arithmetic wraps; no carry or overflow is reported. Example: all-ones + 1 = 0.
- A_IN and B_IN slices are don't-care except at the grant edge.
- **Reset** (asynchronous, any state)
  - State = IDLE, PTR = 0.
  - GNT = 0, SUM_VALID = 0, SUM_OUT = 0, SUM_ID = 0.
  - Operand registers are cleared.
  - Any in-flight or held result is discarded and never re-presented.

## Timing
- Grant edge t: GNT[i] is high during cycle t..t+1.
- Edge t+1: SUM_VALID rises with the final SUM_OUT. Latency from grant to valid is 1 cycle.
- The earliest transfer is at edge t+2. The next grant is no earlier than the edge after the transfer.
- Peak throughput is one operation per 3 cycles.
- Fairness: a continuously asserted requester is granted within NREQ grants.
- The same requester can be granted back-to-back only if no other REQ bit is set.
- After reset, the first arbitration starts with requester 0 as highest priority.

## Test plan
- **Single request:** REQ = 0001, A = 5, B = 7, OUT_READY = 1 → GNT = 0001 for 1 cycle; next cycle SUM_OUT = 12, SUM_ID = 0, SUM_VALID = 1 for exactly 1 cycle.
- **Round-robin:** REQ = 1111 held high (each requester re-requests after its grant), OUT_READY = 1 → grant order 0, 1, 2, 3, 0; each SUM_ID matches its requester.
- **Back-pressure:** OUT_READY = 0 for 10 cycles after valid → SUM_OUT, SUM_ID and SUM_VALID stable; GNT stays 0 despite a pending REQ = 0100. After OUT_READY = 1, requester 2 is granted 1 cycle later.
- **Wrap-around:** A = 0xFFFF_FFFF_FFFF_FFFF, B = 1 → SUM_OUT = 0. A = 0x8000_0000_0000_0000, B = 0x8000_0000_0000_0000 → SUM_OUT = 0.
- **Reset mid-operation:** Rst low while in HOLD with SUM_VALID = 1 → all outputs 0 immediately (asynchronously). After release with REQ = 1010, requester 1 is granted first (PTR = 0).
- **Operand isolation:** change requester 0's A_IN the cycle after its grant → the result reflects the operands latched at the grant edge.
